// File: rtl/pipe_hazard_ctrl.sv
// Control-hazard sequencer: holds the PC and squashes fetches behind BEQ/BNE/JR/LW,
// and carries branch/JR tags to RF/EX. Optional PIPE_HAZARD_PERF_EN adds stall_count.
module pipe_hazard_ctrl #(
  parameter int BR_STALL = 2,
  parameter int LW_STALL = 1,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        beq_if,
  input  logic        bne_if,
  input  logic        jr_if,
  input  logic        lw_if,
  input  logic        j_if,
  output logic        stall_pc,
  output logic        nop_sel,
  output logic        beq_rf,
  output logic        bne_rf,
  output logic        jr_rf,
  output logic        beq_ex,
  output logic        bne_ex,
  output logic        busy
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0] stall_count
`endif
);

  localparam logic [1:0] S_RUN     = 2'd0;
  localparam logic [1:0] S_BR_WAIT = 2'd1;
  localparam logic [1:0] S_JR_WAIT = 2'd2;
  localparam logic [1:0] S_LD_WAIT = 2'd3;

  localparam logic [CNT_W-1:0] BR_INIT = CNT_W'(BR_STALL - 1);
  localparam logic [CNT_W-1:0] LW_INIT = CNT_W'(LW_STALL - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             beq_rf_q, beq_rf_d;
  logic             bne_rf_q, bne_rf_d;
  logic             jr_rf_q, jr_rf_d;
  logic             beq_ex_q, beq_ex_d;
  logic             bne_ex_q, bne_ex_d;

  logic run;
  logic br_hz, jr_hz, lw_hz, hz;
  logic stall_c, nop_c;

  always_comb begin
    run   = (state_q == S_RUN);
    // Priority: branch over JR over LW; j_if never stalls.
    br_hz = (beq_if | bne_if) & run;
    jr_hz = jr_if & run & ~(beq_if | bne_if);
    lw_hz = lw_if & run & ~(beq_if | bne_if | jr_if);
    hz    = br_hz | jr_hz | lw_hz;

    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    nop_c   = 1'b0;

    case (state_q)
      S_RUN: begin
        stall_c = hz;
        nop_c   = hz;
        if (br_hz) begin
          cnt_d = BR_INIT;
          if (BR_INIT != '0) state_d = S_BR_WAIT;
        end else if (jr_hz) begin
          cnt_d   = '0;
          state_d = S_JR_WAIT;
        end else if (lw_hz) begin
          cnt_d = LW_INIT;
          if (LW_INIT != '0) state_d = S_LD_WAIT;
        end else if (j_if) begin
          state_d = S_RUN;
          cnt_d   = cnt_q;
        end
      end
      S_JR_WAIT: begin
        nop_c   = 1'b1;
        state_d = S_RUN;
      end
      default: begin
        nop_c   = 1'b1;
        stall_c = (cnt_q != '0);
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        // Leave on the edge that takes cnt to zero, so stall drops in RUN.
        if (cnt_q <= CNT_W'(1)) state_d = S_RUN;
      end
    endcase

    beq_rf_d = beq_if & run;
    bne_rf_d = bne_if & run;
    jr_rf_d  = jr_if & run;
    beq_ex_d = beq_rf_q;
    bne_ex_d = bne_rf_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_RUN;
      cnt_q    <= '0;
      beq_rf_q <= 1'b0;
      bne_rf_q <= 1'b0;
      jr_rf_q  <= 1'b0;
      beq_ex_q <= 1'b0;
      bne_ex_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      beq_rf_q <= beq_rf_d;
      bne_rf_q <= bne_rf_d;
      jr_rf_q  <= jr_rf_d;
      beq_ex_q <= beq_ex_d;
      bne_ex_q <= bne_ex_d;
    end
  end

  assign stall_pc = stall_c & ~reset;
  assign nop_sel  = nop_c & ~reset;
  assign beq_rf   = beq_rf_q;
  assign bne_rf   = bne_rf_q;
  assign jr_rf    = jr_rf_q;
  assign beq_ex   = beq_ex_q;
  assign bne_ex   = bne_ex_q;
  assign busy     = ~run;

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q + {31'd0, stall_pc};
  end

  always_ff @(posedge clk) begin
    if (reset) stall_count_q <= '0;
    else       stall_count_q <= stall_count_d;
  end

  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: default instance plus an LW_STALL=3 instance
// sharing the same stimulus.
module tb_pipe_hazard_ctrl;
  logic clk;
  logic reset, beq_if, bne_if, jr_if, lw_if, j_if;
  logic stall_pc, nop_sel, beq_rf, bne_rf, jr_rf, beq_ex, bne_ex, busy;
  logic l3_stall_pc, l3_nop_sel, l3_beq_rf, l3_bne_rf, l3_jr_rf, l3_beq_ex, l3_bne_ex, l3_busy;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_count, l3_stall_count;
`endif

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset), .beq_if(beq_if), .bne_if(bne_if), .jr_if(jr_if),
    .lw_if(lw_if), .j_if(j_if), .stall_pc(stall_pc), .nop_sel(nop_sel),
    .beq_rf(beq_rf), .bne_rf(bne_rf), .jr_rf(jr_rf), .beq_ex(beq_ex),
    .bne_ex(bne_ex), .busy(busy)
`ifdef PIPE_HAZARD_PERF_EN
    , .stall_count(stall_count)
`endif
  );

  pipe_hazard_ctrl #(.LW_STALL(3)) dut_lw3 (
    .clk(clk), .reset(reset), .beq_if(beq_if), .bne_if(bne_if), .jr_if(jr_if),
    .lw_if(lw_if), .j_if(j_if), .stall_pc(l3_stall_pc), .nop_sel(l3_nop_sel),
    .beq_rf(l3_beq_rf), .bne_rf(l3_bne_rf), .jr_rf(l3_jr_rf), .beq_ex(l3_beq_ex),
    .bne_ex(l3_bne_ex), .busy(l3_busy)
`ifdef PIPE_HAZARD_PERF_EN
    , .stall_count(l3_stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; beq_if = 1'b1; bne_if = 1'b0; jr_if = 1'b0; lw_if = 1'b0; j_if = 1'b0;

    // Reset held 3 cycles with beq_if asserted
    for (int i = 0; i < 3; i++) begin
      tick; #1;
      chk("rst_stall", stall_pc, 0);
      chk("rst_nop", nop_sel, 0);
      chk("rst_tags", {beq_rf, bne_rf, jr_rf, beq_ex, bne_ex}, 0);
      chk("rst_busy", busy, 0);
    end
    $display("reset: stall=%0b nop=%0b busy=%0b", stall_pc, nop_sel, busy);

    // Branch: release reset with beq_if still high (cycle N)
    reset = 1'b0; #1;
    chk("br_n_stall", stall_pc, 1);
    chk("br_n_nop", nop_sel, 1);
    chk("br_n_busy", busy, 0);
    tick; beq_if = 1'b0; #1;
    chk("br_n1_stall", stall_pc, 1);
    chk("br_n1_nop", nop_sel, 1);
    chk("br_n1_busy", busy, 1);
    chk("br_n1_beq_rf", beq_rf, 1);
    tick; #1;
    chk("br_n2_stall", stall_pc, 0);
    chk("br_n2_nop", nop_sel, 0);
    chk("br_n2_busy", busy, 0);
    chk("br_n2_beq_rf", beq_rf, 0);
    chk("br_n2_beq_ex", beq_ex, 1);
    tick; #1;
    chk("br_n3_beq_ex", beq_ex, 0);
    $display("beq: done checks=%0d", checks);

    // JR
    tick; jr_if = 1'b1; #1;
    chk("jr_n_stall", stall_pc, 1);
    chk("jr_n_nop", nop_sel, 1);
    tick; jr_if = 1'b0; #1;
    chk("jr_n1_stall", stall_pc, 0);
    chk("jr_n1_nop", nop_sel, 1);
    chk("jr_n1_busy", busy, 1);
    chk("jr_n1_jr_rf", jr_rf, 1);
    tick; #1;
    chk("jr_n2_nop", nop_sel, 0);
    chk("jr_n2_busy", busy, 0);
    chk("jr_n2_jr_rf", jr_rf, 0);
    $display("jr: done checks=%0d", checks);

    // LW: default (1 cycle) and LW_STALL=3 instance
    tick; lw_if = 1'b1; #1;
    chk("lw_n_stall", stall_pc, 1);
    chk("lw_n_nop", nop_sel, 1);
    chk("lw3_n_stall", l3_stall_pc, 1);
    tick; lw_if = 1'b0; #1;
    chk("lw_n1_stall", stall_pc, 0);
    chk("lw_n1_busy", busy, 0);
    chk("lw3_n1_stall", l3_stall_pc, 1);
    chk("lw3_n1_busy", l3_busy, 1);
    tick; #1;
    chk("lw3_n2_stall", l3_stall_pc, 1);
    tick; #1;
    chk("lw3_n3_stall", l3_stall_pc, 0);
    chk("lw3_n3_busy", l3_busy, 0);
    chk("lw3_n3_nop", l3_nop_sel, 0);
    $display("lw: done checks=%0d", checks);

    // BEQ+LW together, then BNE during BR_WAIT
    tick; beq_if = 1'b1; lw_if = 1'b1; #1;
    chk("pri_n_stall", stall_pc, 1);
    tick; beq_if = 1'b0; lw_if = 1'b0; bne_if = 1'b1; #1;
    chk("pri_n1_stall", stall_pc, 1);
    chk("pri_n1_busy", busy, 1);
    chk("pri_n1_beq_rf", beq_rf, 1);
    chk("pri_n1_bne_rf", bne_rf, 0);
    tick; bne_if = 1'b0; #1;
    chk("pri_n2_stall", stall_pc, 0);
    chk("pri_n2_bne_rf", bne_rf, 0);
    chk("pri_n2_beq_ex", beq_ex, 1);
    chk("pri_n2_busy", busy, 0);
    chk("pri_n2_lw3_busy", l3_busy, 0);
    $display("priority: done checks=%0d", checks);

    // J alone: no stall
    tick; j_if = 1'b1; #1;
    chk("j_stall", stall_pc, 0);
    chk("j_nop", nop_sel, 0);
    tick; j_if = 1'b0; #1;
    chk("j_busy", busy, 0);
    $display("j: done checks=%0d", checks);

    // Stall accounting: reset, then two branches and one LW -> 5 stall cycles
    tick; reset = 1'b1;
    tick; reset = 1'b0;
    tick; beq_if = 1'b1;
    tick; beq_if = 1'b0;
    tick; tick; bne_if = 1'b1;
    tick; bne_if = 1'b0;
    tick; tick; lw_if = 1'b1;
    tick; lw_if = 1'b0;
    tick; tick; #1;
    chk("perf_idle_busy", busy, 0);
`ifdef PIPE_HAZARD_PERF_EN
    chk("perf_count5", stall_count, 5);
    $display("perf: stall_count=%0d", stall_count);
`endif

    // Reset mid-BR_WAIT aborts the wait
    tick; beq_if = 1'b1;
    tick; beq_if = 1'b0; #1;
    chk("abort_busy_pre", busy, 1);
    reset = 1'b1; #1;
    chk("abort_rst_stall", stall_pc, 0);
    chk("abort_rst_nop", nop_sel, 0);
    tick; reset = 1'b0; #1;
    chk("abort_busy", busy, 0);
    chk("abort_stall", stall_pc, 0);
    chk("abort_nop", nop_sel, 0);
`ifdef PIPE_HAZARD_PERF_EN
    chk("abort_count", stall_count, 0);
`endif
    $display("abort: busy=%0b stall=%0b", busy, stall_pc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
